module_memory_arbiter: RTL and testbench

- Shares the single port of the data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the loader/DMA path.
- Arbitrates one access per cycle using round-robin priority, with optional locked bursts bounded by MAX_BURST.
- Returns read data one cycle after the grant, matching the registered read of the data memory.
- Sits between the requesters and the data memory; the memory port signals connect to it directly.

---
 rtl/module_memory_arbiter.sv | 95 +++++++++
 tb/tb_module_memory_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/module_memory_arbiter.sv
// module_memory_arbiter: round-robin arbiter with bounded locked bursts sharing one data memory port between two requesters
module module_memory_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int MAX_BURST    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_0,
    input  logic                    we_0,
    input  logic                    lock_0,
    input  logic [ADDRESS_BITS-1:0] addr_0,
    input  logic [WORD_SIZE-1:0]    wdata_0,
    output logic                    gnt_0,
    output logic                    rvalid_0,
    output logic [WORD_SIZE-1:0]    rdata_0,
    input  logic                    req_1,
    input  logic                    we_1,
    input  logic                    lock_1,
    input  logic [ADDRESS_BITS-1:0] addr_1,
    input  logic [WORD_SIZE-1:0]    wdata_1,
    output logic                    gnt_1,
    output logic                    rvalid_1,
    output logic [WORD_SIZE-1:0]    rdata_1,
    output logic                    mem_we,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    input  logic [WORD_SIZE-1:0]    mem_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;
    owner_t owner_q, owner_d;
    logic prio_q, prio_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_port_q, rd_port_d;
    logic [WORD_SIZE-1:0] rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;
    logic own_0, own_1, gnt_any, g_we, g_lock;
    logic [4:0] cnt_inc;
    always_comb begin
        own_0 = owner_q == OWN_P0 && req_0;
        own_1 = owner_q == OWN_P1 && req_1;
        gnt_0 = !reset && (own_0 || (!own_1 && req_0 && (!req_1 || !prio_q)));
        gnt_1 = !reset && !gnt_0 && (own_1 || (!own_0 && req_1 && (!req_0 || prio_q)));
        gnt_any = gnt_0 || gnt_1;
        g_we = gnt_1 ? we_1 : we_0;
        g_lock = gnt_1 ? lock_1 : lock_0;
        mem_we = gnt_any && g_we;
        mem_addr = gnt_1 ? addr_1 : addr_0;
        mem_wdata = gnt_1 ? wdata_1 : wdata_0;
        // a burst count only carries over when the current owner is the one being granted
        cnt_inc = {1'b0, (own_0 || own_1) ? burst_cnt_q : 4'd0} + 5'd1;
        owner_d = owner_q;
        burst_cnt_d = burst_cnt_q;
        prio_d = prio_q;
        if (gnt_any && g_lock && cnt_inc < 5'(MAX_BURST)) begin
            owner_d = gnt_1 ? OWN_P1 : OWN_P0;
            burst_cnt_d = cnt_inc[3:0];
        end else if (gnt_any) begin
            owner_d = OWN_NONE;
            burst_cnt_d = 4'd0;
            prio_d = !gnt_1;
        end else if (owner_q != OWN_NONE) begin
            owner_d = OWN_NONE;
            burst_cnt_d = 4'd0;
            prio_d = owner_q == OWN_P0;
        end
        rd_pend_d = gnt_any && !g_we;
        rd_port_d = gnt_1;
        rvalid_0 = !reset && rd_pend_q && !rd_port_q;
        rvalid_1 = !reset && rd_pend_q && rd_port_q;
        rdata_0 = rvalid_0 ? mem_rdata : rdata_0_q;
        rdata_1 = rvalid_1 ? mem_rdata : rdata_1_q;
        rdata_0_d = rdata_0;
        rdata_1_d = rdata_1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            prio_q <= 1'b0;
            burst_cnt_q <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
            rdata_0_q <= '0;
            rdata_1_q <= '0;
        end else begin
            owner_q <= owner_d;
            prio_q <= prio_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
            rdata_0_q <= rdata_0_d;
            rdata_1_q <= rdata_1_d;
        end
    end
endmodule

// File: tb/tb_module_memory_arbiter.sv
// tb_module_memory_arbiter: directed table-driven checks plus multi-cycle lock and reset sequences
module tb_module_memory_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_0 = 0, we_0 = 0, lock_0 = 0, req_1 = 0, we_1 = 0, lock_1 = 0;
    logic [31:0] addr_0 = 0, wdata_0 = 0, addr_1 = 0, wdata_1 = 0;
    logic gnt_0, rvalid_0, gnt_1, rvalid_1, mem_we;
    logic [31:0] rdata_0, rdata_1, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [16];
    logic preload = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    module_memory_arbiter #(.WORD_SIZE(32), .ADDRESS_BITS(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + 32'(i);
            mem[5] <= 32'hDEADBEEF;
        end else begin
            mem_rdata <= mem[mem_addr[3:0]];
            if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    typedef struct {
        logic rst;
        logic r0, w0, l0;
        logic [31:0] a0, d0;
        logic r1, w1, l1;
        logic [31:0] a1, d1;
        logic g0, g1, v0, v1, we;
        logic [31:0] q0, q1;
    } vec_t;

    function automatic vec_t mk(logic rst, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                                logic g0, logic g1, logic v0, logic v1, logic we,
                                logic [31:0] q0, logic [31:0] q1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.l0 = 0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = 0; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.we = we; v.q0 = q0; v.q1 = q1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        {req_0, we_0, lock_0, req_1, we_1, lock_1} = '0;
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    vec_t tbl [18];
    logic exp_g1 [6] = '{1, 1, 1, 1, 0, 1};
    logic exp_g0 [4] = '{1, 1, 1, 0};

    initial begin
        tbl[0]  = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,0,0, 0, 0);
        tbl[1]  = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,0,0, 0, 0);
        tbl[2]  = mk(0, 1,0,5,0,     0,0,0,0,     1,0,0,0,0, 0, 0);
        tbl[3]  = mk(0, 0,0,0,0,     0,0,0,0,     0,0,1,0,0, 32'hDEADBEEF, 0);
        tbl[4]  = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,0,0, 32'hDEADBEEF, 0);
        tbl[5]  = mk(1, 1,0,1,0,     1,0,1,0,     0,0,0,0,0, 32'hDEADBEEF, 0);
        tbl[6]  = mk(0, 1,1,2,32'h11, 1,1,3,32'h22, 1,0,0,0,1, 0, 0);
        tbl[7]  = mk(0, 1,1,2,32'h11, 1,1,3,32'h22, 0,1,0,0,1, 0, 0);
        tbl[8]  = mk(0, 1,0,3,0,     1,0,2,0,     1,0,0,0,0, 0, 0);
        tbl[9]  = mk(0, 1,0,3,0,     1,0,2,0,     0,1,1,0,0, 32'h22, 0);
        tbl[10] = mk(0, 1,0,3,0,     1,0,2,0,     1,0,0,1,0, 32'h22, 32'h11);
        tbl[11] = mk(0, 1,0,3,0,     1,0,2,0,     0,1,1,0,0, 32'h22, 32'h11);
        tbl[12] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,1,0, 32'h22, 32'h11);
        tbl[13] = mk(0, 1,0,0,0,     0,0,0,0,     1,0,0,0,0, 32'h22, 32'h11);
        tbl[14] = mk(0, 1,0,1,0,     0,0,0,0,     1,0,1,0,0, 32'h100, 32'h11);
        tbl[15] = mk(0, 1,0,2,0,     0,0,0,0,     1,0,1,0,0, 32'h101, 32'h11);
        tbl[16] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,1,0,0, 32'h11, 32'h11);
        tbl[17] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,0,0, 32'h11, 32'h11);

        next_cycle();
        preload = 0;
        next_cycle();
        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst;
            req_0 = tbl[i].r0; we_0 = tbl[i].w0; lock_0 = tbl[i].l0; addr_0 = tbl[i].a0; wdata_0 = tbl[i].d0;
            req_1 = tbl[i].r1; we_1 = tbl[i].w1; lock_1 = tbl[i].l1; addr_1 = tbl[i].a1; wdata_1 = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt_0", i), 32'(gnt_0), 32'(tbl[i].g0));
            chk($sformatf("v%0d_gnt_1", i), 32'(gnt_1), 32'(tbl[i].g1));
            chk($sformatf("v%0d_rvalid_0", i), 32'(rvalid_0), 32'(tbl[i].v0));
            chk($sformatf("v%0d_rvalid_1", i), 32'(rvalid_1), 32'(tbl[i].v1));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
            chk($sformatf("v%0d_rdata_0", i), rdata_0, tbl[i].q0);
            chk($sformatf("v%0d_rdata_1", i), rdata_1, tbl[i].q1);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].g1 ? tbl[i].a1 : tbl[i].a0);
            next_cycle();
        end

        do_reset();
        req_1 = 1; lock_1 = 1; addr_1 = 7;
        for (int i = 0; i < 6; i++) begin
            req_0 = i > 0;
            @(negedge clk);
            chk($sformatf("burst%0d_gnt_1", i), 32'(gnt_1), 32'(exp_g1[i]));
            chk($sformatf("burst%0d_gnt_0", i), 32'(gnt_0), 32'(!exp_g1[i]));
            next_cycle();
        end

        do_reset();
        req_0 = 1; lock_0 = 1; addr_0 = 4;
        for (int i = 0; i < 4; i++) begin
            req_1 = i > 0;
            lock_0 = i < 2;
            @(negedge clk);
            chk($sformatf("unlock%0d_gnt_0", i), 32'(gnt_0), 32'(exp_g0[i]));
            chk($sformatf("unlock%0d_gnt_1", i), 32'(gnt_1), 32'(!exp_g0[i]));
            next_cycle();
        end

        do_reset();
        req_0 = 1; we_0 = 0; lock_0 = 0; addr_0 = 5; req_1 = 1; we_1 = 0; addr_1 = 6;
        @(negedge clk);
        chk("rstmid_gnt_0", 32'(gnt_0), 32'd1);
        next_cycle();
        reset = 1; req_0 = 0; req_1 = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid%0d_rvalid_0", i), 32'(rvalid_0), 32'd0);
            chk($sformatf("rstmid%0d_mem_we", i), 32'(mem_we), 32'd0);
            next_cycle();
        end
        reset = 0; req_0 = 1; req_1 = 1;
        @(negedge clk);
        chk("rstmid_after_rvalid_0", 32'(rvalid_0), 32'd0);
        chk("rstmid_after_prio_gnt_0", 32'(gnt_0), 32'd1);
        chk("rstmid_after_rdata_0", rdata_0, 32'd0);
        next_cycle();
        req_0 = 0; req_1 = 0;
        @(negedge clk);
        chk("rstmid_read_rvalid_0", 32'(rvalid_0), 32'd1);
        chk("rstmid_read_rdata_0", rdata_0, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
